mips_multicycle_controller: RTL and testbench

- Multicycle successor to the single-cycle MIPS controller.
- Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Adds a mem_req/mem_ready wait-state handshake, an illegal-opcode trap, and a retire pulse.
- Sits beside the multicycle datapath; the existing aludec is reused for ALU function decode.

---
 rtl/mips_mc_pkg.sv | 94 +++++++++
 rtl/aludec.sv | 39 +++
 rtl/mips_multicycle_controller.sv | 189 ++++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// Opcode classification helpers live here so decode stays in one place.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    START, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, IEXEC, IWB, BRANCH, JUMP, ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic half;
    logic b;
    logic lbu;
  } bh_t;

  function automatic logic is_bh(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic bh_t bh_decode(input logic [5:0] op);
    bh_t r;
    r = '0;
    case (op)
      OP_LH:   r.half = 1'b1;
      OP_LHU:  begin r.half = 1'b1; r.lbu = 1'b1; end
      OP_LB:   r.b = 1'b1;
      OP_LBU:  begin r.b = 1'b1; r.lbu = 1'b1; end
      OP_SH:   r.half = 1'b1;
      OP_SB:   r.b = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic state_t decode_next(
    input logic [5:0] op,
    input logic       bh_en
  );
    logic is_mem;
    logic is_imm;
    state_t s;
    is_mem = (op == OP_LW) || (op == OP_SW) || (bh_en && is_bh(op));
    is_imm = (op == OP_ADDI) || (op == OP_ANDI) ||
             (op == OP_ORI) || (op == OP_SLTI);
    unique case (1'b1)
      is_mem:                          s = MEMADR;
      (op == OP_RTYPE):                s = EXECUTE;
      (op == OP_BEQ || op == OP_BNE):  s = BRANCH;
      is_imm:                          s = IEXEC;
      (op == OP_J):                    s = JUMP;
      default:                         s = ILLEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU function decoder: maps aluop (and funct for R-type) to alucontrol.
module aludec
  import mips_mc_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 4
) (
  input  logic [FUNCT_W-1:0]   funct,
  input  logic [2:0]           aluop,
  output logic [ALUCTRL_W-1:0] alucontrol
);

  logic [3:0] w_ctrl;

  always_comb begin
    w_ctrl = 4'b0000;
    unique case (aluop)
      ALUOP_ADD: w_ctrl = 4'b0010;
      ALUOP_SUB: w_ctrl = 4'b0110;
      ALUOP_AND: w_ctrl = 4'b0000;
      ALUOP_OR:  w_ctrl = 4'b0001;
      ALUOP_SLT: w_ctrl = 4'b0111;
      ALUOP_FUNCT: begin
        case (funct)
          6'b100000: w_ctrl = 4'b0010;
          6'b100010: w_ctrl = 4'b0110;
          6'b100100: w_ctrl = 4'b0000;
          6'b100101: w_ctrl = 4'b0001;
          6'b101010: w_ctrl = 4'b0111;
          default:   w_ctrl = 4'b0000;
        endcase
      end
      default: w_ctrl = 4'b0000;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(w_ctrl);

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore FSM controller for the multicycle MIPS datapath with memory
// wait states, illegal-opcode trap and a retire pulse.
module mips_multicycle_controller
  import mips_mc_pkg::*;
#(
  parameter int OP_W         = 6,
  parameter int FUNCT_W      = 6,
  parameter int ALUCTRL_W    = 4,
  parameter bit BYTE_HALF_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      op,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 iord,
  output logic                 irwrite,
  output logic                 memwrite,
  output logic                 regwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 half,
  output logic                 b,
  output logic                 lbu,
  output logic                 illegal_op,
  output logic                 instr_done
);

  state_t                r_state;
  state_t                w_next;
  logic [OP_W-1:0]       r_op;
  logic [2:0]            w_aluop;
  logic                  w_pcwrite;
  logic                  w_branch;
  logic                  w_ne;
  logic                  w_memphase;
  bh_t                   w_bh;
  logic [ALUCTRL_W-1:0]  w_aluctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= START;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_op <= op;
    end
  end

  assign w_bh = BYTE_HALF_EN ? bh_decode(r_op) : '0;

  always_comb begin
    w_next     = r_state;
    w_aluop    = ALUOP_ADD;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_ne       = 1'b0;
    w_memphase = 1'b0;
    mem_req    = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PCSRC_ALU;
    half       = 1'b0;
    b          = 1'b0;
    lbu        = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    unique case (r_state)
      START: w_next = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = SRCB_4;
        irwrite   = mem_ready;
        w_pcwrite = mem_ready;
        if (mem_ready) w_next = DECODE;
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH;
        w_next  = decode_next(op, BYTE_HALF_EN);
      end
      MEMADR: begin
        w_memphase = 1'b1;
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        w_next     = is_store(r_op) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        w_memphase = 1'b1;
        mem_req    = 1'b1;
        iord       = 1'b1;
        if (mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        w_memphase = 1'b1;
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
        w_next     = FETCH;
      end
      MEMWR: begin
        w_memphase = 1'b1;
        mem_req    = 1'b1;
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) w_next = FETCH;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
        w_next  = ALUWB;
      end
      ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
        w_next     = FETCH;
      end
      IEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        case (r_op)
          OP_ANDI: w_aluop = ALUOP_AND;
          OP_ORI:  w_aluop = ALUOP_OR;
          OP_SLTI: w_aluop = ALUOP_SLT;
          default: w_aluop = ALUOP_ADD;
        endcase
        w_next = IWB;
      end
      IWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = FETCH;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        w_aluop    = ALUOP_SUB;
        pcsrc      = PCSRC_ALUOUT;
        w_branch   = 1'b1;
        w_ne       = (r_op == OP_BNE);
        instr_done = 1'b1;
        w_next     = FETCH;
      end
      JUMP: begin
        pcsrc      = PCSRC_JUMP;
        w_pcwrite  = 1'b1;
        instr_done = 1'b1;
        w_next     = FETCH;
      end
      ILLEGAL: begin
        illegal_op = 1'b1;
        w_next     = FETCH;
      end
      default: w_next = START;
    endcase
    // width hint bits only mean something while the access is in flight
    if (w_memphase) begin
      half = w_bh.half;
      b    = w_bh.b;
      lbu  = w_bh.lbu;
    end
  end

  aludec #(
    .FUNCT_W   (FUNCT_W),
    .ALUCTRL_W (ALUCTRL_W)
  ) u_aludec (
    .funct      (funct),
    .aluop      (w_aluop),
    .alucontrol (w_aluctrl)
  );

  assign alucontrol = (r_state == START) ? '0 : w_aluctrl;
  assign pcen = w_pcwrite | (w_branch & (zero ^ w_ne));

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench: directed per-cycle vectors queued by the stimulus,
// compared at the falling edge by an independent monitor.
module tb_mips_multicycle_controller;
  import mips_mc_pkg::*;

  typedef logic [21:0] vec_t;
  typedef struct packed {
    vec_t e1;
    vec_t c1;
    vec_t e2;
    vec_t c2;
  } exp_t;

  localparam vec_t MR   = vec_t'(1) << 21;
  localparam vec_t IORD = vec_t'(1) << 20;
  localparam vec_t IRW  = vec_t'(1) << 19;
  localparam vec_t MW   = vec_t'(1) << 18;
  localparam vec_t RW   = vec_t'(1) << 17;
  localparam vec_t RD   = vec_t'(1) << 16;
  localparam vec_t M2R  = vec_t'(1) << 15;
  localparam vec_t SA   = vec_t'(1) << 14;
  localparam vec_t PCEN = vec_t'(1) << 9;
  localparam vec_t HALF = vec_t'(1) << 4;
  localparam vec_t BB   = vec_t'(1) << 3;
  localparam vec_t LBU  = vec_t'(1) << 2;
  localparam vec_t ILLB = vec_t'(1) << 1;
  localparam vec_t DONE = vec_t'(1);
  localparam vec_t SB4  = vec_t'(2'b01) << 12;
  localparam vec_t SBI  = vec_t'(2'b10) << 12;
  localparam vec_t SBIS = vec_t'(2'b11) << 12;
  localparam vec_t PC1  = vec_t'(2'b01) << 10;
  localparam vec_t PC2  = vec_t'(2'b10) << 10;
  localparam vec_t A_ADD = vec_t'(4'b0010) << 5;
  localparam vec_t A_SUB = vec_t'(4'b0110) << 5;
  localparam vec_t A_OR  = vec_t'(4'b0001) << 5;
  localparam vec_t ALLC  = '1;
  localparam vec_t NOALU = ~(vec_t'(4'hF) << 5);

  localparam vec_t E_FET  = MR | IRW | SB4 | PCEN | A_ADD;
  localparam vec_t E_FETW = MR | SB4 | A_ADD;
  localparam vec_t E_DEC  = SBIS | A_ADD;
  localparam vec_t E_MADR = SA | SBI | A_ADD;
  localparam vec_t E_MRD  = MR | IORD;
  localparam vec_t E_MWB  = RW | M2R | DONE;
  localparam vec_t E_MWRW = MR | IORD | MW;
  localparam vec_t E_MWR  = MR | IORD | MW | DONE;
  localparam vec_t E_AWB  = RW | RD | DONE;
  localparam vec_t E_IWB  = RW | DONE;
  localparam vec_t E_BR   = SA | PC1 | DONE | A_SUB;
  localparam vec_t E_JMP  = PC2 | PCEN | DONE;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic [5:0] op, funct;
  logic       zero, rdy;
  logic [5:0] op_bad;

  logic mem_req_a, iord_a, irwrite_a, memwrite_a, regwrite_a, regdst_a;
  logic memtoreg_a, alusrca_a, pcen_a, half_a, b_a, lbu_a, ill_a, done_a;
  logic [1:0] alusrcb_a, pcsrc_a;
  logic [3:0] aluc_a;
  logic mem_req_b, iord_b, irwrite_b, memwrite_b, regwrite_b, regdst_b;
  logic memtoreg_b, alusrca_b, pcen_b, half_b, b_b, lbu_b, ill_b, done_b;
  logic [1:0] alusrcb_b, pcsrc_b;
  logic [3:0] aluc_b;
  vec_t v1, v2;

  int   total = 0;
  int   bad = 0;
  exp_t eq[$];
  string nq[$];
  exp_t m_x;
  string m_n;

  always #5 clk = ~clk;

  mips_multicycle_controller u_dut (
    .clk(clk), .reset(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ready(rdy), .mem_req(mem_req_a), .iord(iord_a),
    .irwrite(irwrite_a), .memwrite(memwrite_a), .regwrite(regwrite_a),
    .regdst(regdst_a), .memtoreg(memtoreg_a), .alusrca(alusrca_a),
    .alusrcb(alusrcb_a), .pcsrc(pcsrc_a), .pcen(pcen_a),
    .alucontrol(aluc_a), .half(half_a), .b(b_a), .lbu(lbu_a),
    .illegal_op(ill_a), .instr_done(done_a)
  );

  mips_multicycle_controller #(.BYTE_HALF_EN(1'b0)) u_dut_nobh (
    .clk(clk), .reset(rst2), .op(op), .funct(funct), .zero(zero),
    .mem_ready(rdy), .mem_req(mem_req_b), .iord(iord_b),
    .irwrite(irwrite_b), .memwrite(memwrite_b), .regwrite(regwrite_b),
    .regdst(regdst_b), .memtoreg(memtoreg_b), .alusrca(alusrca_b),
    .alusrcb(alusrcb_b), .pcsrc(pcsrc_b), .pcen(pcen_b),
    .alucontrol(aluc_b), .half(half_b), .b(b_b), .lbu(lbu_b),
    .illegal_op(ill_b), .instr_done(done_b)
  );

  assign v1 = {mem_req_a, iord_a, irwrite_a, memwrite_a, regwrite_a,
               regdst_a, memtoreg_a, alusrca_a, alusrcb_a, pcsrc_a,
               pcen_a, aluc_a, half_a, b_a, lbu_a, ill_a, done_a};
  assign v2 = {mem_req_b, iord_b, irwrite_b, memwrite_b, regwrite_b,
               regdst_b, memtoreg_b, alusrca_b, alusrcb_b, pcsrc_b,
               pcen_b, aluc_b, half_b, b_b, lbu_b, ill_b, done_b};

  task automatic chk(input string n, input vec_t act,
                     input vec_t e, input vec_t c);
    total++;
    if (((act ^ e) & c) != '0) begin
      bad++;
      $display("FAIL %s: got %h expected %h (care %h)",
               n, act & c, e & c, c);
    end
  endtask

  always @(negedge clk) begin
    if (eq.size() > 0) begin
      m_x = eq.pop_front();
      m_n = nq.pop_front();
      chk(m_n, v1, m_x.e1, m_x.c1);
      chk({m_n, " nobh"}, v2, m_x.e2, m_x.c2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex2(input string n, input vec_t e1, input bit a1,
                     input vec_t e2, input bit a2);
    exp_t x;
    x.e1 = e1;
    x.c1 = a1 ? ALLC : NOALU;
    x.e2 = e2;
    x.c2 = a2 ? ALLC : NOALU;
    eq.push_back(x);
    nq.push_back(n);
  endtask

  task automatic ex(input string n, input vec_t e, input bit a);
    ex2(n, e, a, '0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rst2 = 1'b0; op = '0; funct = '0;
    zero = 1'b0; rdy = 1'b1; op_bad = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      tick(); ex("reset", '0, 1);
    end
    tick(); rst = 1'b1; ex("start", '0, 1);
    // lw, 5 cycles
    tick(); op = OP_LW; ex("lw fetch", E_FET, 1);
    tick(); ex("lw decode", E_DEC, 1);
    tick(); ex("lw memadr", E_MADR, 1);
    tick(); ex("lw memrd", E_MRD, 0);
    tick(); ex("lw memwb", E_MWB, 0);
    // sw with three wait states
    tick(); op = OP_SW; ex("sw fetch", E_FET, 1);
    tick(); rdy = 1'b0; ex("sw decode", E_DEC, 1);
    tick(); ex("sw memadr", E_MADR, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); ex("sw wait", E_MWRW, 0);
    end
    tick(); rdy = 1'b1; ex("sw done", E_MWR, 0);
    // bne taken / not taken, with a fetch stall first
    tick(); op = OP_BNE; rdy = 1'b0; ex("fetch stall", E_FETW, 1);
    tick(); rdy = 1'b1; ex("bne fetch", E_FET, 1);
    tick(); ex("bne decode", E_DEC, 1);
    tick(); zero = 1'b0; ex("bne nz", E_BR | PCEN, 1);
    tick(); ex("bne fetch2", E_FET, 1);
    tick(); ex("bne decode2", E_DEC, 1);
    tick(); zero = 1'b1; ex("bne z", E_BR, 1);
    tick(); op = OP_BEQ; ex("beq fetch", E_FET, 1);
    tick(); ex("beq decode", E_DEC, 1);
    tick(); zero = 1'b0; ex("beq nz", E_BR, 1);
    tick(); ex("beq fetch2", E_FET, 1);
    tick(); ex("beq decode2", E_DEC, 1);
    tick(); zero = 1'b1; ex("beq z", E_BR | PCEN, 1);
    // R-type sub
    tick(); op = OP_RTYPE; funct = 6'b100010; ex("r fetch", E_FET, 1);
    tick(); ex("r decode", E_DEC, 1);
    tick(); ex("r execute", SA | A_SUB, 1);
    tick(); ex("r aluwb", E_AWB, 0);
    // ori
    tick(); op = OP_ORI; ex("ori fetch", E_FET, 1);
    tick(); ex("ori decode", E_DEC, 1);
    tick(); ex("ori iexec", SA | SBI | A_OR, 1);
    tick(); ex("ori iwb", E_IWB, 0);
    // lbu and sh width hints
    tick(); op = OP_LBU; ex("lbu fetch", E_FET, 1);
    tick(); ex("lbu decode", E_DEC, 1);
    tick(); ex("lbu memadr", E_MADR | BB | LBU, 1);
    tick(); ex("lbu memrd", E_MRD | BB | LBU, 0);
    tick(); ex("lbu memwb", E_MWB | BB | LBU, 0);
    tick(); op = OP_SH; ex("sh fetch", E_FET, 1);
    tick(); ex("sh decode", E_DEC, 1);
    tick(); ex("sh memadr", E_MADR | HALF, 1);
    tick(); ex("sh memwr", E_MWR | HALF, 0);
    // jump
    tick(); op = OP_J; ex("j fetch", E_FET, 1);
    tick(); ex("j decode", E_DEC, 1);
    tick(); ex("j jump", E_JMP, 0);
    // illegal opcode pulses for a single cycle
    tick(); op = op_bad; ex("ill fetch", E_FET, 1);
    tick(); ex("ill decode", E_DEC, 1);
    tick(); ex("ill trap", ILLB, 0);
    tick(); op = OP_LW; ex("ill back fetch", E_FET, 1);
    // async reset in the middle of a pending read
    tick(); ex("lw2 decode", E_DEC, 1);
    tick(); ex("lw2 memadr", E_MADR, 1);
    tick(); rdy = 1'b0; ex("lw2 memrd", E_MRD, 0);
    tick(); rst = 1'b0; ex("async reset", '0, 1);
    tick(); ex("reset hold", '0, 1);
    // lbu on both builds: byte/half disabled must trap
    tick(); rst = 1'b1; rst2 = 1'b1; op = OP_LBU; rdy = 1'b1;
    ex2("start2", '0, 1, '0, 1);
    tick(); ex2("lbu2 fetch", E_FET, 1, E_FET, 1);
    tick(); ex2("lbu2 decode", E_DEC, 1, E_DEC, 1);
    tick(); ex2("lbu2 memadr", E_MADR | BB | LBU, 1, ILLB, 0);
    tick(); ex2("lbu2 memrd", E_MRD | BB | LBU, 0, E_FET, 1);
    tick(); ex2("lbu2 memwb", E_MWB | BB | LBU, 0, E_DEC, 1);
    @(negedge clk);
    #1;
    total++;
    if (eq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", eq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
